// File: rtl/game_pkg.sv
// Shared chess-board types and default geometry for the VGA game layer.
// Holds the move-selection state type and the board origin/square size.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PICK,
        SELECT,
        COMMIT,
        HANDOFF
    } sel_state_t;

    localparam int BOARD_X0 = 256;
    localparam int BOARD_Y0 = 128;
    localparam int SQ_LOG2  = 6;

endpackage

// File: rtl/board_cursor_decode.sv
// Combinational pixel to {row, col} board square converter.
// Shared by the move selector and the highlight renderer.
module board_cursor_decode #(
    parameter int BOARD_X0 = game_pkg::BOARD_X0,
    parameter int BOARD_Y0 = game_pkg::BOARD_Y0,
    parameter int SQ_LOG2  = game_pkg::SQ_LOG2,
    parameter int ROW_W    = 3,
    parameter int COL_W    = 3
) (
    input  logic [11:0]            xpos,
    input  logic [11:0]            ypos,
    output logic [ROW_W+COL_W-1:0] pos,
    output logic                   in_board
);

    localparam int W_PIX = (1 << COL_W) << SQ_LOG2;
    localparam int H_PIX = (1 << ROW_W) << SQ_LOG2;

    logic [12:0] xe, ye;
    logic [11:0] dx, dy, sx, sy;
    logic        in_x, in_y;

    always_comb begin
        xe = {1'b0, xpos};
        ye = {1'b0, ypos};
        in_x = (xe >= 13'(BOARD_X0)) && (xe < 13'(BOARD_X0 + W_PIX));
        in_y = (ye >= 13'(BOARD_Y0)) && (ye < 13'(BOARD_Y0 + H_PIX));
        in_board = in_x && in_y;
        // Origin subtraction wraps in 12 bits; only meaningful when in_board.
        dx = xpos - 12'(BOARD_X0);
        dy = ypos - 12'(BOARD_Y0);
        sx = dx >> SQ_LOG2;
        sy = dy >> SQ_LOG2;
        pos = {sy[ROW_W-1:0], sx[COL_W-1:0]};
    end

endmodule

// File: rtl/move_selector.sv
// Cursor decode and pick/select/commit FSM handing moves to the game layer.
// Optional abandon-on-inactivity timeout: define MOVE_SELECTOR_TIMEOUT_EN.
module move_selector #(
    parameter int BOARD_X0       = game_pkg::BOARD_X0,
    parameter int BOARD_Y0       = game_pkg::BOARD_Y0,
    parameter int SQ_LOG2        = game_pkg::SQ_LOG2,
    parameter int ROW_W          = 3,
    parameter int COL_W          = 3,
    parameter int TIMEOUT_FRAMES = 600,
    localparam int POS_W         = ROW_W + COL_W,
    localparam int NSQ           = 1 << POS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic [11:0]      mouse_xpos,
    input  logic [11:0]      mouse_ypos,
    input  logic             mouse_left,
    input  logic             my_turn,
    input  logic [NSQ-1:0]   own_piece,
    input  logic [NSQ-1:0]   possible_moves,
    input  logic             move_ack,
    output logic [POS_W-1:0] cursor_pos,
    output logic             cursor_in_board,
    output logic             pick_active,
    output logic [POS_W-1:0] pick_pos,
    output logic             move_valid,
    output logic [POS_W-1:0] move_from,
    output logic [POS_W-1:0] move_to,
    output logic             sel_timeout
);

    import game_pkg::*;

    sel_state_t       state;
    logic [POS_W-1:0] cur;
    logic             in_board;
    logic             btn_prev;
    logic             press;
    logic             hit_own;
    logic             hit_move;
    logic             to_fire;

    board_cursor_decode #(
        .BOARD_X0 (BOARD_X0),
        .BOARD_Y0 (BOARD_Y0),
        .SQ_LOG2  (SQ_LOG2),
        .ROW_W    (ROW_W),
        .COL_W    (COL_W)
    ) u_decode (
        .xpos     (mouse_xpos),
        .ypos     (mouse_ypos),
        .pos      (cur),
        .in_board (in_board)
    );

    assign press    = mouse_left && !btn_prev;
    assign hit_own  = own_piece[cur];
    assign hit_move = possible_moves[cur];

`ifdef MOVE_SELECTOR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_FRAMES + 1);
    logic [CNT_W-1:0] to_cnt;
    logic             waiting;

    assign waiting = (state == PICK) || (state == SELECT);
    // A press restarts the inactivity window, so it never fires with a press.
    assign to_fire = frame_tick && waiting && !press &&
                     (int'(to_cnt) + 1 >= TIMEOUT_FRAMES);

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (frame_tick && press) begin
            to_cnt <= '0;
        end else if (frame_tick && waiting) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT_FRAMES;
    assign to_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            btn_prev        <= 1'b0;
            cursor_pos      <= '0;
            cursor_in_board <= 1'b0;
            pick_active     <= 1'b0;
            pick_pos        <= '0;
            move_valid      <= 1'b0;
            move_from       <= '0;
            move_to         <= '0;
            sel_timeout     <= 1'b0;
        end else begin
            sel_timeout <= 1'b0;
            if (frame_tick) begin
                btn_prev        <= mouse_left;
                cursor_in_board <= in_board;
                if (in_board) cursor_pos <= cur;
            end
            if (to_fire) begin
                state       <= IDLE;
                pick_active <= 1'b0;
                sel_timeout <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (frame_tick && press && my_turn &&
                            in_board && hit_own) begin
                            state       <= PICK;
                            pick_pos    <= cur;
                            pick_active <= 1'b1;
                        end
                    end
                    PICK: begin
                        if (frame_tick && !mouse_left) state <= SELECT;
                    end
                    SELECT: begin
                        if (frame_tick) begin
                            if (!my_turn) begin
                                state       <= IDLE;
                                pick_active <= 1'b0;
                            end else if (press && in_board) begin
                                if (cur == pick_pos) begin
                                    state       <= IDLE;
                                    pick_active <= 1'b0;
                                end else if (hit_own) begin
                                    state    <= PICK;
                                    pick_pos <= cur;
                                end else if (hit_move) begin
                                    state   <= COMMIT;
                                    move_to <= cur;
                                end
                            end
                        end
                    end
                    COMMIT: begin
                        if (frame_tick && !mouse_left) begin
                            state       <= HANDOFF;
                            move_from   <= pick_pos;
                            move_valid  <= 1'b1;
                            pick_active <= 1'b0;
                        end
                    end
                    HANDOFF: begin
                        // Handshake runs at clk rate, independent of frames.
                        if (move_ack) begin
                            state      <= IDLE;
                            move_valid <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
